// File: rtl/gshare_update_unit_pkg.sv
// Shared types, constants and helper functions for the gshare predictor update path.
package gshare_update_unit_pkg;

    localparam int GSHARE_GHSR_WIDTH = 10;
    localparam int GSHARE_PHT_SIZE   = 1024;
    localparam int GHSR_W            = GSHARE_GHSR_WIDTH;
    localparam int PHT_IDX_W         = $clog2(GSHARE_PHT_SIZE);

    // Weakly not-taken
    localparam logic [1:0]  PHT_INIT = 2'b01;
    localparam logic [31:0] PC_INIT  = 32'h0000_0000;

    // Prediction snapshot carried down the pipe from IF to EX
    typedef struct packed {
        logic              branch_taken_predict;
        logic              branch_btb_hit;
        logic [31:0]       branch_btb_addr;
        logic [GHSR_W-1:0] current_GHSR;
    } branch_predict_type;

    // One in-flight PHT update (U1 stage)
    typedef struct packed {
        logic [PHT_IDX_W-1:0] idx;
        logic                 taken;
        logic                 valid;
    } bp_update_type;

    // Index is history XOR word-address bits; pc[1] is ignored so halfword branches alias their word
    function automatic logic [PHT_IDX_W-1:0] gshare_hash(input logic [GHSR_W-1:0] ghsr,
                                                         input logic [31:0]       pc);
        logic unused_pc;
        unused_pc = ^{pc[31:GHSR_W+2], pc[1:0]};
        return ghsr ^ pc[GHSR_W+1:2];
    endfunction

    function automatic logic if_branch_taken(input logic [1:0] cnt);
        return cnt[1];
    endfunction

    function automatic logic [1:0] sat_counter_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
        end
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/gshare_update_unit_if.sv
// IF-side prediction, EX-side resolve and redirect/BTB-write signals of the update unit.
interface gshare_update_unit_if;
    import gshare_update_unit_pkg::*;

    logic               if_pc_dummy_unused;
    logic [31:0]        if_pc;
    logic               if_is_branch;
    logic               if_stall;
    logic               pred_taken;
    logic [GHSR_W-1:0]  pred_ghsr;

    logic               ex_valid;
    logic               ex_is_branch;
    logic [31:0]        ex_pc;
    logic               ex_is_compressed;
    logic               ex_taken;
    logic [31:0]        ex_target;
    branch_predict_type ex_bp;

    logic               mispredict;
    logic [31:0]        redirect_pc;
    logic               btb_wr_en;
    logic [31:0]        btb_wr_pc;
    logic [31:0]        btb_wr_target;

    modport master (
        output if_pc, if_is_branch, if_stall,
        output ex_valid, ex_is_branch, ex_pc, ex_is_compressed, ex_taken, ex_target, ex_bp,
        input  pred_taken, pred_ghsr,
        input  mispredict, redirect_pc, btb_wr_en, btb_wr_pc, btb_wr_target
    );

    modport slave (
        input  if_pc, if_is_branch, if_stall,
        input  ex_valid, ex_is_branch, ex_pc, ex_is_compressed, ex_taken, ex_target, ex_bp,
        output pred_taken, pred_ghsr,
        output mispredict, redirect_pc, btb_wr_en, btb_wr_pc, btb_wr_target
    );

endinterface

// File: rtl/gshare_update_unit_pht.sv
// 2-bit counter pattern history table: combinational IF read with write bypass, separate
// update-side read port, single write port.
module gshare_update_unit_pht
    import gshare_update_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PHT_IDX_W-1:0] rd_idx,
    output logic [1:0]           rd_cnt,
    input  logic [PHT_IDX_W-1:0] upd_rd_idx,
    output logic [1:0]           upd_rd_cnt,
    input  logic                 wr_en,
    input  logic [PHT_IDX_W-1:0] wr_idx,
    input  logic [1:0]           wr_cnt
);

    logic [1:0] pht [GSHARE_PHT_SIZE];

    // Counter array; whole table returns to weakly not-taken on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < GSHARE_PHT_SIZE; i++) begin
                pht[i] <= PHT_INIT;
            end
        end else if (wr_en) begin
            pht[wr_idx] <= wr_cnt;
        end
    end

    // IF sees the counter being written this cycle rather than the stale array value
    assign rd_cnt     = (wr_en && (wr_idx == rd_idx)) ? wr_cnt : pht[rd_idx];
    assign upd_rd_cnt = pht[upd_rd_idx];

endmodule

// File: rtl/gshare_update_unit.sv
// Resolve-side gshare: GHSR, prediction to IF, PHT retraining pipeline, redirect and BTB write.
module gshare_update_unit
    import gshare_update_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    gshare_update_unit_if.slave  bus
);

    logic [GHSR_W-1:0]    ghsr;
    logic [PHT_IDX_W-1:0] if_idx;
    logic [PHT_IDX_W-1:0] u0_idx;
    logic [1:0]           if_cnt;
    logic [1:0]           u0_arr_cnt;
    logic [1:0]           u0_cnt;
    logic [1:0]           u1_cnt;
    logic [1:0]           u1_new_cnt;
    bp_update_type        u1;
    logic                 resolve;
    logic                 dir_wrong;
    logic                 tgt_wrong;

    assign if_idx         = gshare_hash(ghsr, bus.if_pc);
    assign bus.pred_taken = if_branch_taken(if_cnt);
    assign bus.pred_ghsr  = ghsr;

    assign resolve   = bus.ex_valid & bus.ex_is_branch;
    assign dir_wrong = bus.ex_taken != bus.ex_bp.branch_taken_predict;
    assign tgt_wrong = bus.ex_taken & (!bus.ex_bp.branch_btb_hit |
                                       (bus.ex_bp.branch_btb_addr != bus.ex_target));

    // U0 reads the counter now; an update to the same index still sitting in U1 is newer
    assign u0_idx     = gshare_hash(bus.ex_bp.current_GHSR, bus.ex_pc);
    assign u1_new_cnt = sat_counter_update(u1_cnt, u1.taken);
    assign u0_cnt     = (u1.valid && (u1.idx == u0_idx)) ? u1_new_cnt : u0_arr_cnt;

    gshare_update_unit_pht u_pht (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_idx     (if_idx),
        .rd_cnt     (if_cnt),
        .upd_rd_idx (u0_idx),
        .upd_rd_cnt (u0_arr_cnt),
        .wr_en      (u1.valid),
        .wr_idx     (u1.idx),
        .wr_cnt     (u1_new_cnt)
    );

    // U1 stage register: index, direction and the counter value to be incremented/decremented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            u1     <= '0;
            u1_cnt <= PHT_INIT;
        end else begin
            u1     <= '{idx: u0_idx, taken: bus.ex_taken, valid: resolve};
            u1_cnt <= u0_cnt;
        end
    end

    // Speculative history: direction repair overrides the IF shift (that IF slot gets flushed)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghsr <= '0;
        end else if (resolve && dir_wrong) begin
            ghsr <= {bus.ex_bp.current_GHSR[GHSR_W-2:0], bus.ex_taken};
        end else if (bus.if_is_branch && !bus.if_stall) begin
            ghsr <= {ghsr[GHSR_W-2:0], bus.pred_taken};
        end
    end

    // Registered one-cycle mispredict / BTB-write strobes with their payloads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.mispredict    <= 1'b0;
            bus.btb_wr_en     <= 1'b0;
            bus.redirect_pc   <= PC_INIT;
            bus.btb_wr_pc     <= '0;
            bus.btb_wr_target <= '0;
        end else begin
            bus.mispredict <= resolve & (dir_wrong | tgt_wrong);
            bus.btb_wr_en  <= resolve & tgt_wrong;
            if (resolve) begin
                bus.redirect_pc   <= bus.ex_taken ? bus.ex_target :
                                     bus.ex_pc + (bus.ex_is_compressed ? 32'd2 : 32'd4);
                bus.btb_wr_pc     <= bus.ex_pc;
                bus.btb_wr_target <= bus.ex_target;
            end
        end
    end

endmodule
